// File: rtl/axilite_uart_host.sv
// AXI-lite initiator for a 16550A register block: programs LCR once, then polls
// LSR, draining RBR into a one-entry rx register and feeding THR from a one-entry tx register.
module axilite_uart_host #(
    parameter logic [31:0] UART_BASE_ADDR = 32'h0000_0000,
    parameter int unsigned POLL_GAP       = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        err,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);
    localparam logic [31:0] ADDR_DATA = UART_BASE_ADDR;          // RBR/THR and LCR share word 0
    localparam logic [31:0] ADDR_LSR  = UART_BASE_ADDR + 32'd4;
    localparam logic [7:0]  LCR_8N1   = 8'h03;
    localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);

    typedef enum logic [2:0] {INIT, IDLE, POLL, RD_RBR, WR_THR, GAP} state_t;
    state_t state_q, state_d;

    logic [15:0] gap_cnt;
    logic [7:0]  tx_byte;
    logic [7:0]  lsr;
    logic        wr_started, init_done, tx_full;
    logic        b_done, r_done, rd_enter, in_wr_state;
    logic        rdata_unused;

    assign lsr          = m_rdata[15:8];
    assign rdata_unused = ^m_rdata[31:16];
    assign in_wr_state  = (state_q == INIT) || (state_q == WR_THR);
    // Response channels open only once the address/data handshakes are finished.
    assign m_bready     = in_wr_state && wr_started && !m_awvalid && !m_wvalid;
    assign m_rready     = ((state_q == POLL) || (state_q == RD_RBR)) && !m_arvalid;
    assign b_done       = m_bvalid && m_bready;
    assign r_done       = m_rvalid && m_rready;
    assign tx_ready     = init_done && !tx_full;
    assign rd_enter     = (state_d != state_q) && ((state_d == POLL) || (state_d == RD_RBR));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= INIT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:   if (b_done) state_d = IDLE;
            IDLE:   state_d = POLL;
            POLL: begin
                if (r_done) begin
                    if (lsr[0] && !rx_valid)     state_d = RD_RBR;
                    else if (lsr[5] && tx_full)  state_d = WR_THR;
                    else                         state_d = GAP;
                end
            end
            RD_RBR: if (r_done) state_d = IDLE;
            WR_THR: if (b_done) state_d = IDLE;
            GAP:    if (gap_cnt == GAP_LAST) state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    // Write issue: one AW+W pair per visit to INIT/WR_THR, each valid retired by its own ready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_awvalid  <= 1'b0;
            m_wvalid   <= 1'b0;
            m_awaddr   <= '0;
            m_wdata    <= '0;
            m_wstrb    <= '0;
            wr_started <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                wr_started <= 1'b0;
            end else if (in_wr_state && !wr_started) begin
                wr_started <= 1'b1;
                m_awvalid  <= 1'b1;
                m_wvalid   <= 1'b1;
                m_awaddr   <= ADDR_DATA;
                if (state_q == INIT) begin
                    m_wstrb <= 4'b1000;
                    m_wdata <= {4{LCR_8N1}};
                end else begin
                    m_wstrb <= 4'b0001;
                    m_wdata <= {4{tx_byte}};
                end
            end
            if (m_awvalid && m_awready) m_awvalid <= 1'b0;
            if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_arvalid <= 1'b0;
            m_araddr  <= '0;
        end else if (rd_enter) begin
            m_arvalid <= 1'b1;
            m_araddr  <= (state_d == POLL) ? ADDR_LSR : ADDR_DATA;
        end else if (m_arvalid && m_arready) begin
            m_arvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)              gap_cnt <= '0;
        else if (state_q != GAP)   gap_cnt <= '0;
        else                       gap_cnt <= gap_cnt + 16'd1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_byte   <= '0;
            tx_full   <= 1'b0;
            init_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= (b_done && (m_bresp != 2'b00)) || (r_done && (m_rresp != 2'b00));
            if (state_q == INIT && b_done) init_done <= 1'b1;
            // A fresh load wins over a same-cycle consumer pop.
            if (state_q == RD_RBR && r_done && m_rresp == 2'b00) begin
                rx_data  <= m_rdata[7:0];
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (state_q == WR_THR && b_done) tx_full <= 1'b0;
            if (tx_valid && tx_ready) begin
                tx_full <= 1'b1;
                tx_byte <= tx_data;
            end
        end
    end
endmodule

// File: tb/tb_axilite_uart_host.sv
// Bench for axilite_uart_host: a behavioural 16550 slave with configurable
// AW latency and responses, logging every transaction for ordering/latency checks.
module tb_axilite_uart_host;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          PG   = 8;
    localparam logic [31:0] LSR_A = BASE + 32'd4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready, err;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;

    axilite_uart_host #(.UART_BASE_ADDR(BASE), .POLL_GAP(PG)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .err(err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [31:0] addr; logic [3:0] strb; logic [31:0] data; int cyc; int seq; } wr_t;
    typedef struct { logic [31:0] addr; int cyc; int seq; } rd_t;
    wr_t wr_q[$];
    rd_t rd_q[$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, seq = 0;
    int aw_delay, aw_wait;
    logic aw_got, w_got, rsp_is_rbr;
    logic [31:0] aw_a, w_d;
    logic [3:0]  w_s;
    logic [7:0]  lsr_val, rbr_val;
    logic [1:0]  rbr_resp, bresp_cfg;
    logic aw_hs, w_hs;

    assign m_awready = m_awvalid && !aw_got && (aw_wait + 1 >= aw_delay);
    assign m_wready  = m_wvalid && !w_got;
    assign m_arready = m_arvalid && !m_rvalid;
    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;

    always @(posedge aclk) cyc <= cyc + 1;

    // Slave model: B/R responses arrive one cycle after the completing handshake.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0;
            m_bvalid <= 1'b0; m_bresp <= 2'b00;
            m_rvalid <= 1'b0; m_rresp <= 2'b00; m_rdata <= '0; rsp_is_rbr <= 1'b0;
        end else begin
            if (m_awvalid && !m_awready) aw_wait <= aw_wait + 1;
            else                         aw_wait <= 0;
            if ((aw_got || aw_hs) && (w_got || w_hs) && !m_bvalid) begin
                wr_q.push_back('{aw_hs ? m_awaddr : aw_a, w_hs ? m_wstrb : w_s,
                                 w_hs ? m_wdata : w_d, cyc, seq});
                seq <= seq + 1;
                m_bvalid <= 1'b1; m_bresp <= bresp_cfg;
                aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_a <= m_awaddr; end
                if (w_hs)  begin w_got <= 1'b1; w_d <= m_wdata; w_s <= m_wstrb; end
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if (m_arvalid && m_arready) begin
                rd_q.push_back('{m_araddr, cyc, seq});
                seq <= seq + 1;
                m_rvalid <= 1'b1;
                if (m_araddr == BASE) begin
                    m_rdata <= ($urandom() & 32'hFFFF_FF00) | {24'h0, rbr_val};
                    m_rresp <= rbr_resp; rsp_is_rbr <= 1'b1;
                end else begin
                    m_rdata <= ($urandom() & 32'hFFFF_00FF) | {16'h0, lsr_val, 8'h0};
                    m_rresp <= 2'b00; rsp_is_rbr <= 1'b0;
                end
            end else if (m_rvalid && m_rready) begin
                m_rvalid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_wr(input string tag, output wr_t w);
        int n = 0;
        while (wr_q.size() == 0 && n < 300) begin @(negedge aclk); n++; end
        if (wr_q.size() == 0) begin
            chk({tag, "_timeout"}, 32'(wr_q.size()), 32'd1);
            w = '{'x, 'x, 'x, -1, -1};
        end else w = wr_q.pop_front();
    endtask

    task automatic wait_rd(input string tag, output rd_t r);
        int n = 0;
        while (rd_q.size() == 0 && n < 300) begin @(negedge aclk); n++; end
        if (rd_q.size() == 0) begin
            chk({tag, "_timeout"}, 32'(rd_q.size()), 32'd1);
            r = '{'x, -1, -1};
        end else r = rd_q.pop_front();
    endtask

    task automatic find_rbr(input string tag, output rd_t r);
        for (int i = 0; i < 6; i++) begin
            wait_rd(tag, r);
            if (r.addr === BASE || r.seq < 0) break;
        end
        chk({tag, "_addr"}, r.addr, BASE);
    endtask

    task automatic send_tx(input logic [7:0] b, output int acc);
        int n = 0;
        while (!tx_ready && n < 300) begin @(negedge aclk); n++; end
        chk("tx_ready_wait", 32'(tx_ready), 32'd1);
        tx_data = b; tx_valid = 1'b1; acc = cyc;
        @(negedge aclk);
        tx_valid = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t w;
        rd_t r;
        int acc, aw_hi, w_hi, viol;
        int pc[3];
        logic [7:0] b, rb;
        logic done;

        aresetn = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
        lsr_val = 8'h60; rbr_val = '0; rbr_resp = 2'b00; bresp_cfg = 2'b00; aw_delay = 0;
        repeat (3) @(negedge aclk);
        chk("rst_awvalid", 32'(m_awvalid), 0);
        chk("rst_wvalid",  32'(m_wvalid), 0);
        chk("rst_arvalid", 32'(m_arvalid), 0);
        chk("rst_bready",  32'(m_bready), 0);
        chk("rst_rready",  32'(m_rready), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_err",     32'(err), 0);
        chk("rst_tx_ready", 32'(tx_ready), 0);

        // LCR programming straight out of reset
        aresetn = 1'b1;
        @(negedge aclk);
        chk("init_awvalid_rise", 32'(m_awvalid), 1);
        chk("init_wvalid_rise",  32'(m_wvalid), 1);
        wait_wr("init", w);
        chk("init_awaddr", w.addr, BASE);
        chk("init_wstrb", 32'(w.strb), 32'h8);
        chk("init_wdata", w.data, 32'h0303_0303);
        chk("init_txrdy_during_b", 32'(tx_ready), 0);
        @(negedge aclk);
        chk("init_txrdy_after_b", 32'(tx_ready), 1);

        // Random THR writes with THRE set
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 12)) @(negedge aclk);
            b = 8'($urandom());
            wr_q.delete();
            send_tx(b, acc);
            chk("tx_ready_full", 32'(tx_ready), 0);
            wait_wr("thr", w);
            chk("thr_awaddr", w.addr, BASE);
            chk("thr_wstrb", 32'(w.strb), 32'h1);
            chk("thr_wdata", w.data, {4{b}});
            chk("thr_latency", 32'(w.cyc - acc <= PG + 7), 1);
            chk("thr_txrdy_during_b", 32'(tx_ready), 0);
            @(negedge aclk);
            chk("thr_txrdy_after_b", 32'(tx_ready), 1);
        end

        // No THRE: the queued byte must wait; then DR+THRE: RBR read precedes THR write
        lsr_val = 8'h00;
        repeat (2 * PG + 10) @(negedge aclk);
        wr_q.delete();
        b = 8'($urandom());
        send_tx(b, acc);
        repeat (2 * PG + 10) @(negedge aclk);
        chk("no_thr_without_thre", 32'(wr_q.size()), 0);
        rd_q.delete();
        rb = 8'($urandom());
        rbr_val = rb; lsr_val = 8'h61;
        find_rbr("prio_rbr", r);
        chk("rx_valid_before_load", 32'(rx_valid), 0);
        @(negedge aclk);
        chk("rx_valid_loaded", 32'(rx_valid), 1);
        chk("rx_data_loaded", 32'(rx_data), 32'(rb));
        wait_wr("prio_thr", w);
        chk("prio_thr_wdata", w.data, {4{b}});
        chk("prio_rbr_before_thr", 32'(r.seq < w.seq), 1);
        chk("rx_valid_held", 32'(rx_valid), 1);

        // Consumer stalled with DR stuck high: only polls, PG idle cycles apart
        rd_q.delete();
        for (int i = 0; i < 3; i++) begin
            wait_rd("stall_poll", r);
            chk("stall_poll_addr", r.addr, LSR_A);
            pc[i] = r.cyc;
        end
        chk("poll_spacing_a", 32'(pc[1] - pc[0]), 32'(PG + 3));
        chk("poll_spacing_b", 32'(pc[2] - pc[1]), 32'(PG + 3));

        // Drain rx and let RBR reads resume
        for (int k = 0; k < 3; k++) begin
            rb = 8'($urandom());
            rbr_val = rb;
            rx_ready = 1'b1;
            @(negedge aclk);
            rx_ready = 1'b0;
            chk("rx_clear", 32'(rx_valid), 0);
            rd_q.delete();
            find_rbr("resume_rbr", r);
            chk("resume_rx_before", 32'(rx_valid), 0);
            @(negedge aclk);
            chk("resume_rx_valid", 32'(rx_valid), 1);
            chk("resume_rx_data", 32'(rx_data), 32'(rb));
        end

        // AW stalled 5 cycles, W immediate
        lsr_val = 8'h60; rx_ready = 1'b1; aw_delay = 5;
        repeat (2 * PG + 10) @(negedge aclk);
        wr_q.delete();
        b = 8'($urandom());
        send_tx(b, acc);
        aw_hi = 0; w_hi = 0; viol = 0; done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge aclk);
            if (m_awvalid) aw_hi++;
            if (m_wvalid) w_hi++;
            if (m_bready && (m_awvalid || m_wvalid)) viol++;
            if (m_bvalid && m_bready) done = 1'b1;
        end
        chk("awdly_done", 32'(done), 1);
        chk("awdly_awvalid_cycles", 32'(aw_hi), 5);
        chk("awdly_wvalid_cycles", 32'(w_hi), 1);
        chk("awdly_bready_early", 32'(viol), 0);
        wait_wr("awdly", w);
        chk("awdly_wdata", w.data, {4{b}});
        aw_delay = 0;

        // SLVERR on RBR read
        rbr_resp = 2'b10; lsr_val = 8'h61;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_rvalid && m_rready && rsp_is_rbr) begin done = 1'b1; break; end
            @(negedge aclk);
        end
        chk("rerr_seen", 32'(done), 1);
        chk("rerr_err_before", 32'(err), 0);
        @(negedge aclk);
        chk("rerr_err_pulse", 32'(err), 1);
        chk("rerr_rx_valid", 32'(rx_valid), 0);
        @(negedge aclk);
        chk("rerr_err_drop", 32'(err), 0);
        chk("rerr_rx_valid_after", 32'(rx_valid), 0);
        rd_q.delete();
        wait_rd("rerr_next", r);
        chk("rerr_next_is_poll", r.addr, LSR_A);
        lsr_val = 8'h60; rbr_resp = 2'b00;

        // Reset in the middle of a stalled write, INIT repeats (with a SLVERR on LCR)
        repeat (2 * PG + 10) @(negedge aclk);
        aw_delay = 5;
        wr_q.delete();
        b = 8'($urandom());
        send_tx(b, acc);
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_awvalid) begin done = 1'b1; break; end
            @(negedge aclk);
        end
        chk("mid_awvalid_seen", 32'(done), 1);
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_awvalid", 32'(m_awvalid), 0);
        chk("mid_rst_wvalid", 32'(m_wvalid), 0);
        chk("mid_rst_arvalid", 32'(m_arvalid), 0);
        chk("mid_rst_bready", 32'(m_bready), 0);
        chk("mid_rst_rready", 32'(m_rready), 0);
        chk("mid_rst_tx_ready", 32'(tx_ready), 0);
        @(negedge aclk);
        aw_delay = 0; bresp_cfg = 2'b10;
        wr_q.delete(); rd_q.delete();
        aresetn = 1'b1;
        @(negedge aclk);
        chk("reinit_awvalid", 32'(m_awvalid), 1);
        wait_wr("reinit", w);
        chk("reinit_awaddr", w.addr, BASE);
        chk("reinit_wstrb", 32'(w.strb), 32'h8);
        chk("reinit_wdata", w.data, 32'h0303_0303);
        chk("reinit_err_before", 32'(err), 0);
        @(negedge aclk);
        chk("reinit_err_pulse", 32'(err), 1);
        chk("reinit_tx_ready", 32'(tx_ready), 1);
        @(negedge aclk);
        chk("reinit_err_drop", 32'(err), 0);
        bresp_cfg = 2'b00;

        b = 8'($urandom());
        wr_q.delete();
        send_tx(b, acc);
        wait_wr("post_thr", w);
        chk("post_thr_wstrb", 32'(w.strb), 32'h1);
        chk("post_thr_wdata", w.data, {4{b}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
